// File: rtl/mem_arbiter_pkg.sv
// Shared bus constants for the memory arbiter: FSM encoding, fetch access size
// and default arbitration/timeout parameters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_TIMEOUT      = 15;

endpackage

// File: rtl/mem_arbiter_access_timer.sv
// Wait counter for an outstanding memory access; expired stays high once the
// count reaches TIMEOUT until the timer is cleared.
module access_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign expired = (count_reg == CNT_W'(TIMEOUT));

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !expired) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory port with
// data priority, fetch starvation guard and access timeout. All outputs registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    arb_state_e  state_reg, state_next;
    logic [2:0]  starve_reg, starve_next;
    logic        if_gnt_reg, if_gnt_next;
    logic        if_rvalid_reg, if_rvalid_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic        d_gnt_reg, d_gnt_next;
    logic        d_rvalid_reg, d_rvalid_next;
    logic [31:0] d_rdata_reg, d_rdata_next;
    logic        err_reg, err_next;
    logic        mem_req_reg, mem_req_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [2:0]  mem_funct3_reg, mem_funct3_next;

    logic grant_d;
    logic grant_if;
    logic busy;
    logic expired;

    assign busy = (state_reg != IDLE);

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_access_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy && !mem_ack),
        .expired (expired)
    );

    // Data normally wins; a fetch that has watched STARVE_LIMIT data grants goes first.
    always_comb begin
        grant_d  = (state_reg == IDLE) && d_req && !(if_req && (starve_reg == STARVE_MAX));
        grant_if = (state_reg == IDLE) && if_req && !grant_d;
    end

    always_comb begin
        starve_next = starve_reg;
        if (!if_req || grant_if) begin
            starve_next = '0;
        end else if (grant_d && (starve_reg != STARVE_MAX)) begin
            starve_next = starve_reg + 3'd1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        if_gnt_next     = 1'b0;
        if_rvalid_next  = 1'b0;
        if_rdata_next   = if_rdata_reg;
        d_gnt_next      = 1'b0;
        d_rvalid_next   = 1'b0;
        d_rdata_next    = d_rdata_reg;
        err_next        = 1'b0;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_funct3_next = mem_funct3_reg;

        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next      = BUSY_D;
                    d_gnt_next      = 1'b1;
                    mem_req_next    = 1'b1;
                    mem_we_next     = d_we;
                    mem_addr_next   = d_addr;
                    mem_wdata_next  = d_wdata;
                    mem_funct3_next = d_funct3;
                end else if (grant_if) begin
                    state_next      = BUSY_IF;
                    if_gnt_next     = 1'b1;
                    mem_req_next    = 1'b1;
                    mem_we_next     = 1'b0;
                    mem_addr_next   = if_addr;
                    mem_wdata_next  = '0;
                    mem_funct3_next = FETCH_FUNCT3;
                end
            end
            BUSY_IF, BUSY_D: begin
                // An ack in the expiry cycle still completes normally.
                if (mem_ack || expired) begin
                    state_next      = IDLE;
                    err_next        = !mem_ack;
                    mem_req_next    = 1'b0;
                    mem_we_next     = 1'b0;
                    mem_addr_next   = '0;
                    mem_wdata_next  = '0;
                    mem_funct3_next = '0;
                    if (state_reg == BUSY_IF) begin
                        if_rvalid_next = 1'b1;
                        if_rdata_next  = mem_ack ? mem_rdata : 32'h0;
                    end else begin
                        d_rvalid_next  = 1'b1;
                        d_rdata_next   = mem_ack ? mem_rdata : 32'h0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            starve_reg     <= '0;
            if_gnt_reg     <= 1'b0;
            if_rvalid_reg  <= 1'b0;
            if_rdata_reg   <= '0;
            d_gnt_reg      <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            d_rdata_reg    <= '0;
            err_reg        <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_funct3_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_reg     <= starve_next;
            if_gnt_reg     <= if_gnt_next;
            if_rvalid_reg  <= if_rvalid_next;
            if_rdata_reg   <= if_rdata_next;
            d_gnt_reg      <= d_gnt_next;
            d_rvalid_reg   <= d_rvalid_next;
            d_rdata_reg    <= d_rdata_next;
            err_reg        <= err_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_funct3_reg <= mem_funct3_next;
        end
    end

    assign if_gnt     = if_gnt_reg;
    assign if_rvalid  = if_rvalid_reg;
    assign if_rdata   = if_rdata_reg;
    assign d_gnt      = d_gnt_reg;
    assign d_rvalid   = d_rvalid_reg;
    assign d_rdata    = d_rdata_reg;
    assign err        = err_reg;
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_funct3 = mem_funct3_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a delay-programmable memory responder plus a
// scoreboard of expected completions checked when rvalid appears.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        resp_ack;
    logic [31:0] resp_data;
    logic        force_ack;
    logic        ack_enable;
    int          ack_delay;
    int          busy_cyc;
    logic        any_out;

    int checks;
    int failures;

    typedef struct {
        bit          is_if;
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_funct3   (d_funct3),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack   = resp_ack | force_ack;
    assign mem_rdata = force_ack ? 32'h1234_5678 : resp_data;
    assign any_out   = |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, err,
                         mem_req, mem_we, mem_addr, mem_wdata, mem_funct3};

    function automatic logic [31:0] resp_for(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    // Memory model: acks ack_delay cycles after mem_req rises.
    always @(negedge clk) begin
        if (!mem_req) begin
            busy_cyc  = 0;
            resp_ack  = 1'b0;
            resp_data = 32'hFFFF_FFFF;
        end else begin
            resp_ack  = ack_enable && (busy_cyc == ack_delay);
            resp_data = resp_ack ? resp_for(mem_addr) : 32'hFFFF_FFFF;
            busy_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit p_if, input logic [31:0] p_data, input bit p_err);
        exp_t e;
        e.is_if = p_if;
        e.rdata = p_data;
        e.err   = p_err;
        sb.push_back(e);
    endtask

    task automatic cmp_done();
        exp_t e;
        chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("rvalid_port", {30'b0, if_rvalid, d_rvalid}, e.is_if ? 32'd2 : 32'd1);
        chk("rdata", e.is_if ? if_rdata : d_rdata, e.rdata);
        chk("err", {31'b0, err}, {31'b0, e.err});
        chk("mem_req_cleared", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic wait_done(input int exp_lat);
        int lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) begin
                lat = i;
                break;
            end
        end
        chk("rvalid_seen", {31'b0, lat != 0}, 32'd1);
        if (lat == 0) return;
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        cmp_done();
    endtask

    task automatic issue(input bit is_if, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            d_req    = 1'b1;
            d_we     = we;
            d_addr   = addr;
            d_wdata  = wdata;
            d_funct3 = f3;
        end
        @(negedge clk);
        chk("gnt", {30'b0, if_gnt, d_gnt}, is_if ? 32'd2 : 32'd1);
        chk("mem_req", {31'b0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, addr);
        chk("mem_we", {31'b0, mem_we}, is_if ? 32'd0 : {31'b0, we});
        chk("mem_funct3", {29'b0, mem_funct3}, is_if ? 32'd2 : {29'b0, f3});
        if (!is_if) chk("mem_wdata", mem_wdata, wdata);
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        int ngnt;
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_funct3   = '0;
        force_ack  = 1'b0;
        ack_enable = 1'b1;
        ack_delay  = 2;

        repeat (2) @(negedge clk);
        chk("reset_outs", {31'b0, any_out}, 32'd0);
        rst = 1'b1;

        // Single fetch, ack two cycles after mem_req; first edge after reset arbitrates.
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3'b010);
        push_exp(1'b1, 32'h0050_0093, 1'b0);
        wait_done(3);

        // Minimum latency data load.
        ack_delay = 0;
        issue(1'b0, 1'b0, 32'h0000_0200, 32'h0, 3'b100);
        push_exp(1'b0, resp_for(32'h200), 1'b0);
        wait_done(1);

        // Simultaneous requests: data store first, fetch one IDLE cycle after d_rvalid.
        ack_delay = 1;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0020;
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h0000_0100;
        d_wdata   = 32'hDEAD_BEEF;
        d_funct3  = 3'b010;
        @(negedge clk);
        chk("both_gnt", {30'b0, if_gnt, d_gnt}, 32'd1);
        chk("store_we", {31'b0, mem_we}, 32'd1);
        chk("store_addr", mem_addr, 32'h0000_0100);
        chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        push_exp(1'b0, resp_for(32'h100), 1'b0);
        wait_done(2);
        chk("if_gnt_at_rvalid", {31'b0, if_gnt}, 32'd0);
        @(negedge clk);
        chk("b2b_if_gnt", {30'b0, if_gnt, d_gnt}, 32'd2);
        chk("b2b_if_addr", mem_addr, 32'h0000_0020);
        chk("b2b_if_f3", {29'b0, mem_funct3}, 32'd2);
        if_req = 1'b0;
        push_exp(1'b1, resp_for(32'h20), 1'b0);
        wait_done(2);

        // Starvation guard: pattern D D D D F D D D D F with both requests held.
        ack_delay = 0;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0040;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h0000_0300;
        d_funct3  = 3'b100;
        ngnt      = 0;
        for (int i = 0; i < 80 && ngnt < 10; i++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) cmp_done();
            if (if_gnt || d_gnt) begin
                chk("starve_order", {31'b0, if_gnt}, (ngnt == 4 || ngnt == 9) ? 32'd1 : 32'd0);
                push_exp(if_gnt, resp_for(if_gnt ? 32'h40 : 32'h300), 1'b0);
                ngnt++;
            end
        end
        chk("starve_grants", ngnt, 32'd10);
        if_req = 1'b0;
        d_req  = 1'b0;
        if (sb.size() != 0) wait_done(-1);

        // Timeout on a data load: rvalid + err 16 cycles after gnt, rdata forced to 0.
        ack_enable = 1'b0;
        issue(1'b0, 1'b0, 32'h0000_0400, 32'h0, 3'b010);
        push_exp(1'b0, 32'h0, 1'b1);
        wait_done(16);
        @(negedge clk);
        chk("err_one_cycle", {31'b0, err}, 32'd0);

        // Ack on the exact expiry cycle wins.
        ack_enable = 1'b1;
        ack_delay  = 15;
        issue(1'b0, 1'b0, 32'h0000_0500, 32'h0, 3'b010);
        push_exp(1'b0, resp_for(32'h500), 1'b0);
        wait_done(16);

        // d_rdata holds across a fetch completion.
        ack_delay = 0;
        issue(1'b1, 1'b0, 32'h0000_0090, 32'h0, 3'b010);
        push_exp(1'b1, resp_for(32'h90), 1'b0);
        wait_done(1);
        chk("d_rdata_hold", d_rdata, resp_for(32'h500));

        // Asynchronous reset mid BUSY_D, late ack ignored, then normal service.
        ack_enable = 1'b0;
        issue(1'b0, 1'b0, 32'h0000_0600, 32'h0, 3'b010);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_rst_outs", {31'b0, any_out}, 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'b0, any_out}, 32'd0);
        end
        force_ack  = 1'b0;
        ack_enable = 1'b1;
        ack_delay  = 0;
        chk("sb_empty", sb.size(), 32'd0);
        issue(1'b1, 1'b0, 32'h0000_0080, 32'h0, 3'b010);
        push_exp(1'b1, resp_for(32'h80), 1'b0);
        wait_done(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
